// File: rtl/bus_decoder.sv
// Clocked address decoder: maps CPU accesses onto N base/mask regions with per-region wait states.
// Latency: mapped access is accepted in IDLE, then 1+WAIT ACCESS cycles and one DONE cycle; unmapped goes straight to DONE.
// Backpressure: req is only sampled in IDLE; a held req is re-accepted at the first IDLE edge, and no queueing is done.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   req/addr/rw      CPU access strobe, address, direction (1 = write)
//   p_do             slave read data, region i at [i*DATA_W +: DATA_W]
//   clr_err          clears the sticky error flag
//   cs/oe/we         one-hot region select, read enable and write enable (ACCESS state only)
//   cpu_di           registered read data, held until the next read completes
//   ready            one-cycle completion pulse (DONE state)
//   err/err_addr     sticky unmapped-access flag and the address of the latest unmapped access
module bus_decoder #(
  parameter int                   ADDR_W   = 16,
  parameter int                   DATA_W   = 8,
  parameter int                   N        = 3,
  parameter logic [N*ADDR_W-1:0]  BASE     = {16'hF000, 16'hE000, 16'h0000},
  parameter logic [N*ADDR_W-1:0]  MASK     = {16'hF000, 16'hFFF0, 16'hF000},
  parameter logic [N*4-1:0]       WAIT     = {4'd0, 4'd1, 4'd0},
  parameter logic [DATA_W-1:0]    OPEN_BUS = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  rw,
  input  logic [N*DATA_W-1:0]   p_do,
  input  logic                  clr_err,
  output logic [N-1:0]          cs,
  output logic [N-1:0]          oe,
  output logic [N-1:0]          we,
  output logic [DATA_W-1:0]     cpu_di,
  output logic                  ready,
  output logic                  err,
  output logic [ADDR_W-1:0]     err_addr
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rw;
  logic [SEL_W-1:0]     r_sel;
  logic [3:0]           r_cnt;
  logic [DATA_W-1:0]    r_cpu_di;
  logic                 r_err;
  logic [ADDR_W-1:0]    r_err_addr;

  logic                 w_hit;
  logic [SEL_W-1:0]     w_sel;
  logic [3:0]           w_wait;
  logic [N-1:0]         w_onehot;
  logic                 w_accept;
  logic                 w_err_set;

  // Region decode of the live address. Scanning from the top index down lets
  // the lowest matching region overwrite any higher one, so it wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((addr & MASK[i*ADDR_W +: ADDR_W]) == (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W])) begin
        w_hit = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
  end

  assign w_wait    = WAIT[int'(w_sel)*4 +: 4];
  assign w_accept  = (r_state == S_IDLE) && req;
  assign w_err_set = w_accept && !w_hit;

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_sel] = 1'b1;
  end

  // Next state and state-decoded outputs. Outputs come straight from the
  // state register so an asynchronous reset drops them at once.
  always_comb begin
    w_state_nxt = r_state;
    cs          = '0;
    oe          = '0;
    we          = '0;
    ready       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt = w_hit ? S_ACCESS : S_DONE;
        end
      end
      S_ACCESS: begin
        cs = w_onehot;
        oe = r_rw ? '0 : w_onehot;
        we = r_rw ? w_onehot : '0;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ready       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rw       <= 1'b0;
      r_sel      <= '0;
      r_cnt      <= 4'd0;
      r_cpu_di   <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_rw  <= rw;
        r_sel <= w_sel;
        r_cnt <= w_hit ? w_wait : 4'd0;
        // Unmapped reads complete in DONE with the open-bus value.
        if (!w_hit && !rw) begin
          r_cpu_di <= OPEN_BUS;
        end
      end

      if (r_state == S_ACCESS) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else if (!r_rw) begin
          // Slave data is sampled only at the final ACCESS edge.
          r_cpu_di <= p_do[int'(r_sel)*DATA_W +: DATA_W];
        end
      end

      // A new unmapped access beats a simultaneous clear.
      r_err <= w_err_set | (r_err & ~clr_err);
      if (w_err_set) begin
        r_err_addr <= addr;
      end
    end
  end

  assign cpu_di   = r_cpu_di;
  assign err      = r_err;
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed and randomised accesses with a completion scoreboard.
// Expected completion values are queued when an access is driven and popped when ready pulses.
// Cycle-level cs/oe/we/ready checks are made by the driving task against a small decode model.
module tb_bus_decoder;

  localparam int          ADDR_W   = 16;
  localparam int          DATA_W   = 8;
  localparam int          N        = 3;
  localparam logic [47:0] BASE_P   = {16'hF000, 16'hE000, 16'h0000};
  localparam logic [47:0] MASK_P   = {16'hF000, 16'hFFF0, 16'hF000};
  localparam logic [11:0] WAIT_P   = {4'd0, 4'd1, 4'd0};
  localparam logic [7:0]  OPEN_BUS = 8'h00;

  logic                 clk;
  logic                 reset;
  logic                 req;
  logic [ADDR_W-1:0]    addr;
  logic                 rw;
  logic [N*DATA_W-1:0]  p_do;
  logic                 clr_err;
  logic [N-1:0]         cs;
  logic [N-1:0]         oe;
  logic [N-1:0]         we;
  logic [DATA_W-1:0]    cpu_di;
  logic                 ready;
  logic                 err;
  logic [ADDR_W-1:0]    err_addr;

  bus_decoder #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N        (N),
    .BASE     (BASE_P),
    .MASK     (MASK_P),
    .WAIT     (WAIT_P),
    .OPEN_BUS (OPEN_BUS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .addr     (addr),
    .rw       (rw),
    .p_do     (p_do),
    .clr_err  (clr_err),
    .cs       (cs),
    .oe       (oe),
    .we       (we),
    .cpu_di   (cpu_di),
    .ready    (ready),
    .err      (err),
    .err_addr (err_addr)
  );

  typedef struct {
    logic [7:0]  cpu;
    logic        err;
    logic [15:0] eaddr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;

  // Architectural model of the completion-visible state.
  logic [7:0]  m_cpu   = 8'h00;
  logic        m_err   = 1'b0;
  logic [15:0] m_eaddr = 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void decode(input logic [15:0] a, output logic hit, output int sel);
    hit = 1'b0;
    sel = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((a & MASK_P[i*16 +: 16]) == (BASE_P[i*16 +: 16] & MASK_P[i*16 +: 16])) begin
        hit = 1'b1;
        sel = i;
      end
    end
  endfunction

  // Completion monitor: every ready pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("ready_unexpected", 32'(ready), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("cpu_di", 32'(cpu_di), 32'(mon_e.cpu));
        chk("err", 32'(err), 32'(mon_e.err));
        chk("err_addr", 32'(err_addr), 32'(mon_e.eaddr));
      end
    end
  end

  // One complete access, starting and ending with the DUT in IDLE.
  task automatic do_access(input logic [15:0] a, input logic w, input logic [7:0] d,
                           input logic clr, input logic hold);
    logic       hit;
    int         sel;
    int         wt;
    logic [2:0] oh;
    exp_t       e;
    decode(a, hit, sel);
    wt = hit ? int'(WAIT_P[sel*4 +: 4]) : 0;
    oh = hit ? 3'(3'b001 << sel) : 3'b000;
    @(negedge clk);
    req     = 1'b1;
    addr    = a;
    rw      = w;
    clr_err = clr;
    for (int i = 0; i < N; i++) p_do[i*8 +: 8] = (hit && i == sel) ? d : ~d;
    if (!hit) begin
      m_err   = 1'b1;
      m_eaddr = a;
      if (!w) m_cpu = OPEN_BUS;
    end else begin
      if (clr) m_err = 1'b0;
      if (!w) m_cpu = d;
    end
    e.cpu   = m_cpu;
    e.err   = m_err;
    e.eaddr = m_eaddr;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    clr_err = 1'b0;
    if (hit) begin
      for (int k = 0; k <= wt; k++) begin
        chk("cs_access", 32'(cs), 32'(oh));
        chk("oe_access", 32'(oe), w ? 32'd0 : 32'(oh));
        chk("we_access", 32'(we), w ? 32'(oh) : 32'd0);
        chk("ready_busy", 32'(ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    chk("ready_done", 32'(ready), 32'd1);
    chk("cs_done", 32'(cs), 32'd0);
    chk("oe_we_done", 32'({oe, we}), 32'd0);
    @(posedge clk); #1;
    chk("ready_idle", 32'(ready), 32'd0);
  endtask

  logic [15:0] base_tab [4] = '{16'h0000, 16'hE000, 16'hF000, 16'h8000};
  logic [15:0] ra;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    req     = 1'b0;
    addr    = '0;
    rw      = 1'b0;
    p_do    = '0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_cpu_di", 32'(cpu_di), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_access(16'h0123, 1'b0, 8'hA5, 1'b0, 1'b0);  // region 0, no wait
    do_access(16'hE004, 1'b0, 8'h3C, 1'b0, 1'b0);  // region 1, one wait
    do_access(16'hF800, 1'b1, 8'h77, 1'b0, 1'b0);  // region 2 write: cpu_di keeps 3C
    do_access(16'h5000, 1'b0, 8'h99, 1'b0, 1'b0);  // unmapped read
    do_access(16'h0F00, 1'b0, 8'h5A, 1'b1, 1'b0);  // mapped read with clear
    do_access(16'h6000, 1'b1, 8'h11, 1'b1, 1'b0);  // unmapped write vs clear: set wins
    do_access(16'hEFF4, 1'b0, 8'h42, 1'b0, 1'b0);  // outside region 1's 16-byte window
    do_access(16'h0010, 1'b0, 8'hC3, 1'b0, 1'b1);  // req held high across completion
    do_access(16'hF000, 1'b1, 8'h24, 1'b0, 1'b0);  // picked up at first IDLE edge

    for (int n = 0; n < 12; n++) begin
      ra = base_tab[$urandom_range(0, 3)] + 16'($urandom_range(0, 255));
      do_access(ra, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
    end

    // Leave err set and cpu_di non-zero, then abort a waited access by reset.
    do_access(16'h7000, 1'b1, 8'h00, 1'b0, 1'b0);
    do_access(16'h0123, 1'b0, 8'hE7, 1'b0, 1'b0);
    @(negedge clk);
    req  = 1'b1;
    addr = 16'hE004;
    rw   = 1'b0;
    p_do = {8'h00, 8'h99, 8'h00};
    @(posedge clk); #1;
    req = 1'b0;
    chk("cs_pre_reset", 32'(cs), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("abort_cs", 32'(cs), 32'd0);
    chk("abort_oe", 32'(oe), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_cpu_di", 32'(cpu_di), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_err_addr", 32'(err_addr), 32'd0);
    m_cpu   = 8'h00;
    m_err   = 1'b0;
    m_eaddr = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("post_reset_ready", 32'(ready), 32'd0);
      chk("post_reset_cs", 32'(cs), 32'd0);
    end

    do_access(16'h0ABC, 1'b0, 8'h6D, 1'b0, 1'b0);  // clean access after abort
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
